// File: rtl/e1_frame_align.sv
// E1 (G.706) receive frame alignment: hunts for the FAS in TS0, confirms it with NFAS and a
// second FAS, then tracks the timeslot and frame position and drops sync on repeated bad FAS.
module e1_frame_align #(
  parameter logic [7:0] FAS_WORD      = 8'h1b,
  parameter logic [7:0] FAS_MASK      = 8'h7f,
  parameter int         NFAS_BIT      = 6,
  parameter int         TS_PER_FRAME  = 32,
  parameter int         FRAMES_PER_MF = 16,
  parameter int         LOSS_COUNT    = 3,
  parameter int         ERRCNT_W      = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       din,
  input  logic                             din_valid,
  output logic [7:0]                       dout,
  output logic                             dout_valid,
  output logic [$clog2(TS_PER_FRAME)-1:0]  ts_idx,
  output logic [$clog2(FRAMES_PER_MF)-1:0] frame_idx,
  output logic                             aligned,
  output logic                             loss_pulse,
  output logic [ERRCNT_W-1:0]              fas_err_cnt,
  output logic [1:0]                       state_dbg
);

  localparam int TS_W = $clog2(TS_PER_FRAME);
  localparam int FR_W = $clog2(FRAMES_PER_MF);

  typedef enum logic [1:0] {HUNT, CHK_NFAS, CHK_FAS, SYNC} state_t;

  // Handshake: a byte is consumed on every cycle din_valid=1 (no backpressure); dout_valid
  // marks the single cycle on which dout and the index outputs describe a newly accepted byte.

  state_t              state_q, state_d;
  logic [TS_W-1:0]     bc_q, bc_d;
  logic [FR_W-1:0]     fc_q, fc_d;
  logic [3:0]          run_q, run_d;
  logic [ERRCNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]          dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [FR_W-1:0]     fi_q, fi_d;
  logic                aligned_q, aligned_d;
  logic                loss_q, loss_d;

  logic                fas_ok;
  logic                bc_last;
  logic [TS_W-1:0]     byte_bc;
  logic [FR_W-1:0]     byte_fc;

  assign fas_ok  = (din & FAS_MASK) == (FAS_WORD & FAS_MASK);
  assign bc_last = bc_q == TS_W'(TS_PER_FRAME - 1);

  always_comb begin
    state_d      = state_q;
    bc_d         = bc_q;
    fc_d         = fc_q;
    run_d        = run_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    ts_d         = ts_q;
    fi_d         = fi_q;
    aligned_d    = aligned_q;
    loss_d       = 1'b0;
    byte_bc      = bc_q;
    byte_fc      = fc_q;

    if (din_valid) begin
      dout_d       = din;
      dout_valid_d = 1'b1;
      bc_d         = bc_last ? '0 : bc_q + 1'b1;
      fc_d         = bc_last ? fc_q + 1'b1 : fc_q;

      case (state_q)
        HUNT: begin
          // A candidate FAS becomes TS0 of frame 0; the counters restart from it.
          if (fas_ok) begin
            state_d = CHK_NFAS;
            byte_bc = '0;
            byte_fc = '0;
            bc_d    = TS_W'(1);
            fc_d    = '0;
          end
        end
        CHK_NFAS: begin
          if (bc_q == '0) state_d = din[NFAS_BIT] ? CHK_FAS : HUNT;
        end
        CHK_FAS: begin
          if (bc_q == '0) begin
            state_d = fas_ok ? SYNC : HUNT;
            run_d   = '0;
          end
        end
        SYNC: begin
          // Only even-frame TS0 carries the FAS; odd-frame TS0 (NFAS) is not supervised.
          if (bc_q == '0 && !fc_q[0]) begin
            if (fas_ok) begin
              run_d = '0;
            end else begin
              run_d = run_q + 1'b1;
              if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
              if (run_q + 4'd1 == 4'(LOSS_COUNT)) begin
                state_d = HUNT;
                loss_d  = 1'b1;
                run_d   = '0;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase

      aligned_d = state_d == SYNC;
      ts_d      = (state_d == HUNT) ? '0 : byte_bc;
      fi_d      = (state_d == HUNT) ? '0 : byte_fc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      bc_q         <= '0;
      fc_q         <= '0;
      run_q        <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ts_q         <= '0;
      fi_q         <= '0;
      aligned_q    <= 1'b0;
      loss_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bc_q         <= bc_d;
      fc_q         <= fc_d;
      run_q        <= run_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ts_q         <= ts_d;
      fi_q         <= fi_d;
      aligned_q    <= aligned_d;
      loss_q       <= loss_d;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign ts_idx      = ts_q;
  assign frame_idx   = fi_q;
  assign aligned     = aligned_q;
  assign loss_pulse  = loss_q;
  assign fas_err_cnt = cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_e1_frame_align.sv
// Bench for e1_frame_align: an offset-from-anchor model of G.706 alignment feeds an expected
// queue that is compared against the DUT every cycle, plus pinned literal checks per scenario.
module tb_e1_frame_align;

  localparam int EW = 36;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = '0;
  logic        din_valid = 1'b0;
  logic [7:0]  dout;
  logic        dout_valid;
  logic [4:0]  ts_idx;
  logic [3:0]  frame_idx;
  logic        aligned;
  logic        loss_pulse;
  logic [15:0] fas_err_cnt;
  logic [1:0]  state_dbg;

  e1_frame_align dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .ts_idx(ts_idx), .frame_idx(frame_idx),
    .aligned(aligned), .loss_pulse(loss_pulse), .fas_err_cnt(fas_err_cnt),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // model: mode 0 hunt, 1 wait NFAS, 2 wait second FAS, 3 in sync
  int m_mode = 0, m_n = 0, m_anchor = 0, m_run = 0, m_cnt = 0;
  logic       m_dv = 0, m_al = 0, m_loss = 0;
  logic [7:0] m_dout = 0;
  int         m_ts = 0, m_fi = 0;
  int         sp = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic model(input logic r, input logic v, input logic [7:0] d);
    int off;
    logic ok;
    if (r) begin
      m_mode = 0; m_n = 0; m_anchor = 0; m_run = 0; m_cnt = 0;
      m_dv = 0; m_al = 0; m_loss = 0; m_dout = 0; m_ts = 0; m_fi = 0;
    end else if (!v) begin
      m_dv = 0; m_loss = 0;
    end else begin
      ok = (d & 8'h7f) == 8'h1b;
      m_loss = 0;
      if (m_mode == 0) begin
        if (ok) begin m_mode = 1; m_anchor = m_n; end
      end else begin
        off = m_n - m_anchor;
        if (off % 32 == 0) begin
          if (m_mode == 1) m_mode = d[6] ? 2 : 0;
          else if (m_mode == 2) begin m_mode = ok ? 3 : 0; m_run = 0; end
          else if ((off / 32) % 2 == 0) begin
            if (ok) m_run = 0;
            else begin
              m_run++;
              if (m_cnt < 65535) m_cnt++;
              if (m_run == 3) begin m_mode = 0; m_loss = 1; m_run = 0; end
            end
          end
        end
      end
      m_dv = 1; m_dout = d; m_al = (m_mode == 3);
      m_ts = (m_mode == 0) ? 0 : (m_n - m_anchor) % 32;
      m_fi = (m_mode == 0) ? 0 : ((m_n - m_anchor) / 32) % 16;
      m_n++;
    end
    exp_q.push_back({m_dv, m_dout, 5'(m_ts), 4'(m_fi), m_al, m_loss, 16'(m_cnt)});
  endtask

  // driver
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    rst = r; din_valid = v; din = d;
    @(posedge clk);
    model(r, v, d);
    #1;
  endtask

  function automatic logic [7:0] gen(input int p, input logic [7:0] fasb, input bit rnd);
    if (p % 32 == 0) return ((p / 32) % 2 == 0) ? fasb : 8'h5f;
    return rnd ? 8'($urandom_range(0, 255)) : 8'h00;
  endfunction

  function automatic logic [7:0] nonfas();
    logic [7:0] r;
    do r = 8'($urandom_range(0, 255)); while ((r & 8'h7f) == 8'h1b);
    return r;
  endfunction

  task automatic send_to(input int target, input logic [7:0] fasb, input bit rnd, input bit gaps);
    while (sp < target) begin
      if (gaps && $urandom_range(0, 1) == 1) step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
      step(1'b0, 1'b1, gen(sp, fasb, rnd));
      sp++;
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    sp = 0;
  endtask

  // scoreboard: every cycle's outputs against the model
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dout_valid", int'(dout_valid), int'(e[35]));
      chk("dout", int'(dout), int'(e[34:27]));
      chk("ts_idx", int'(ts_idx), int'(e[26:22]));
      chk("frame_idx", int'(frame_idx), int'(e[21:18]));
      chk("aligned", int'(aligned), int'(e[17]));
      chk("loss_pulse", int'(loss_pulse), int'(e[16]));
      chk("fas_err_cnt", int'(fas_err_cnt), int'(e[15:0]));
    end
  end

  initial begin
    int target;
    // 1: clean stream, alignment on the third TS0
    do_reset();
    chk("rst_state", int'(state_dbg), 0);
    chk("rst_aligned", int'(aligned), 0);
    chk("rst_cnt", int'(fas_err_cnt), 0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    send_to(64, 8'h1b, 1'b0, 1'b0);
    chk("t1_pre_aligned", int'(aligned), 0);
    chk("t1_pre_ts", int'(ts_idx), 31);
    chk("t1_pre_fi", int'(frame_idx), 1);
    send_to(65, 8'h1b, 1'b0, 1'b0);
    chk("t1_aligned", int'(aligned), 1);
    chk("t1_ts", int'(ts_idx), 0);
    chk("t1_fi", int'(frame_idx), 2);
    send_to(513, 8'h1b, 1'b0, 1'b0);
    chk("t1_fi_wrap", int'(frame_idx), 0);
    chk("t1_aligned_wrap", int'(aligned), 1);

    // 3: two bad FAS then a good one keeps sync
    send_to(576, 8'h1b, 1'b1, 1'b0);
    send_to(577, 8'h1a, 1'b1, 1'b0);
    chk("t3_cnt1", int'(fas_err_cnt), 1);
    send_to(640, 8'h1b, 1'b1, 1'b0);
    send_to(641, 8'h1a, 1'b1, 1'b0);
    chk("t3_cnt2", int'(fas_err_cnt), 2);
    send_to(705, 8'h1b, 1'b1, 1'b0);
    chk("t3_aligned", int'(aligned), 1);
    chk("t3_cnt_hold", int'(fas_err_cnt), 2);

    // 4: three bad FAS drop sync
    do_reset();
    send_to(128, 8'h1b, 1'b1, 1'b0);
    chk("t4_aligned", int'(aligned), 1);
    send_to(129, 8'h1a, 1'b1, 1'b0);
    send_to(192, 8'h1b, 1'b1, 1'b0);
    send_to(193, 8'h1a, 1'b1, 1'b0);
    send_to(256, 8'h1b, 1'b1, 1'b0);
    send_to(257, 8'h1a, 1'b1, 1'b0);
    chk("t4_loss", int'(loss_pulse), 1);
    chk("t4_lost_aligned", int'(aligned), 0);
    chk("t4_lost_ts", int'(ts_idx), 0);
    chk("t4_cnt", int'(fas_err_cnt), 3);
    send_to(258, 8'h1b, 1'b1, 1'b0);
    chk("t4_loss_end", int'(loss_pulse), 0);
    chk("t4_cnt_kept", int'(fas_err_cnt), 3);

    // 2: false FAS rejected by NFAS, then a true FAS aligns
    do_reset();
    for (int k = 0; k < 38; k++) begin
      step(1'b0, 1'b1, (k == 5) ? 8'h1b : (k == 37) ? 8'h00 : nonfas());
      if (k == 5) chk("t2_false_ts", int'(ts_idx), 0);
    end
    chk("t2_rejected_aligned", int'(aligned), 0);
    chk("t2_rejected_ts", int'(ts_idx), 0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, nonfas());
    send_to(65, 8'h1b, 1'b1, 1'b0);
    chk("t2_aligned", int'(aligned), 1);

    // 5: gapped input in sync
    send_to(sp + 300, 8'h1b, 1'b1, 1'b1);
    chk("t5_aligned", int'(aligned), 1);

    // 6: reset at ts 17, then Si=1 FAS aligns
    target = (sp / 32 + 1) * 32 + 17;
    send_to(target, 8'h1b, 1'b1, 1'b0);
    chk("t6_pre_ts", int'(ts_idx), 16);
    step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
    chk("t6_rst_aligned", int'(aligned), 0);
    chk("t6_rst_ts", int'(ts_idx), 0);
    chk("t6_rst_dv", int'(dout_valid), 0);
    chk("t6_rst_dout", int'(dout), 0);
    chk("t6_rst_state", int'(state_dbg), 0);
    sp = 0;
    send_to(65, 8'h9b, 1'b1, 1'b0);
    chk("t6_si_aligned", int'(aligned), 1);

    // random corruption with gaps: losses and relocks against the model
    for (int f = 0; f < 40; f++)
      send_to(sp + 32, ($urandom_range(0, 3) == 0) ? 8'h1a : 8'h1b, 1'b1, 1'b1);

    step(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
